// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit issuing one registered request per access on a req/ack data bus.
// Build option MEM_ALIGN_EXC_EN: misaligned halfword/word accesses raise mem_adel/mem_ades instead of being truncated.
`timescale 1ns/1ps
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_memaddr,
    input  logic [31:0] ex_storedata,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_adel,
    output logic        mem_ades,
    output logic        stallreq,
    output logic [1:0]  dbg_state_o
);

    // Bus handshake: bus_req rises with we/addr/sel/wdata and all of them hold until the
    // cycle bus_ack is sampled high; bus_ack is a one-cycle strobe, ignored outside WAIT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic        addr_err, access;
    logic [1:0]  off;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    always_comb begin
        is_load   = (ex_memop >= OP_LB) && (ex_memop <= OP_LW);
        is_store  = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
        is_byte   = (ex_memop == OP_LB) || (ex_memop == OP_LBU) || (ex_memop == OP_SB);
        is_half   = (ex_memop == OP_LH) || (ex_memop == OP_LHU) || (ex_memop == OP_SH);
        is_word   = (ex_memop == OP_LW) || (ex_memop == OP_SW);
        is_signed = (ex_memop == OP_LB) || (ex_memop == OP_LH);
`ifdef MEM_ALIGN_EXC_EN
        addr_err  = (is_half && ex_memaddr[0]) || (is_word && (ex_memaddr[1:0] != 2'b00));
`else
        addr_err  = 1'b0;
`endif
        access    = (is_load || is_store) && !addr_err;
        // Offset after forcing natural alignment; only matters when misalignment is not trapped.
        if (is_word)
            off = 2'b00;
        else if (is_half)
            off = {ex_memaddr[1], 1'b0};
        else
            off = ex_memaddr[1:0];
    end

    always_comb begin
        lane_sel   = 4'b1111;
        lane_wdata = ex_storedata;
        if (is_byte) begin
            lane_sel   = 4'b1000 >> off;
            lane_wdata = {4{ex_storedata[7:0]}};
        end else if (is_half) begin
            lane_sel   = off[1] ? 4'b0011 : 4'b1100;
            lane_wdata = {2{ex_storedata[15:0]}};
        end
    end

    // Big-endian lanes: offset 0 is bits [31:24].
    always_comb begin
        case (off)
            2'd0:    ld_byte = bus_rdata[31:24];
            2'd1:    ld_byte = bus_rdata[23:16];
            2'd2:    ld_byte = bus_rdata[15:8];
            default: ld_byte = bus_rdata[7:0];
        endcase
        ld_half  = off[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        load_ext = bus_rdata;
        if (is_byte)
            load_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
        else if (is_half)
            load_ext = {{16{is_signed & ld_half[15]}}, ld_half};
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && access) begin
                    state_d     = ST_WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {ex_memaddr[31:2], 2'b00};
                    bus_sel_d   = lane_sel;
                    bus_wdata_d = lane_wdata;
                end
            end
            ST_WAIT: begin
                // Flush beats a coincident ack: the returned data is dropped.
                if (flush) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (bus_ack) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (is_load)
                        rdata_d = load_ext;
                end
            end
            ST_DONE: begin
                if (flush || !stall[4])
                    state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_sel     = bus_sel_q;
    assign bus_wdata   = bus_wdata_q;
    assign dbg_state_o = state_q;

    assign stallreq  = rst && access && ((state_q == ST_IDLE) || (state_q == ST_WAIT));
    assign mem_adel  = rst && addr_err && is_load;
    assign mem_ades  = rst && addr_err && is_store;
    assign mem_wd    = ex_wd;
    assign mem_wreg  = ex_wreg && !addr_err;
    assign mem_wdata = is_load ? rdata_q : ex_wdata;

    // Only the MEM-stage bit of the stall vector concerns this block.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: random load/store stream against a byte-level reference model of mem_access,
// plus directed flush, reset-in-WAIT and DONE-hold scenarios.
`timescale 1ns/1ps
module tb_mem_access;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [1:0] IDLE_ENC = 2'd0;
`ifdef MEM_ALIGN_EXC_EN
    localparam bit ALIGN_EXC = 1'b1;
`else
    localparam bit ALIGN_EXC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [3:0]  ex_memop = '0;
    logic [31:0] ex_memaddr = '0;
    logic [31:0] ex_storedata = '0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_adel, mem_ades, stallreq;
    logic [31:0] mem_wdata;
    logic [1:0]  dbg_state;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_memop(ex_memop), .ex_memaddr(ex_memaddr), .ex_storedata(ex_storedata),
        .stall(stall), .flush(flush),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_adel(mem_adel), .mem_ades(mem_ades), .stallreq(stallreq),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] bus_mem[int unsigned];
    logic [31:0] last_cap = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic bit op_misaligned(input logic [3:0] op, input logic [31:0] addr);
        int s = op_size(op);
        return (s > 1) && ((int'(addr[1:0]) % s) != 0);
    endfunction

    // Byte offset inside the word after rounding down to the access size.
    function automatic int eff_off(input logic [3:0] op, input logic [31:0] addr);
        int s = op_size(op);
        if (s == 0) return 0;
        return (int'(addr[1:0]) / s) * s;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] addr);
        int s = op_size(op);
        int o = eff_off(op, addr);
        return 4'(((1 << s) - 1) << (4 - o - s));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
        int s = op_size(op);
        if (s == 1) return 32'(sd[7:0]) * 32'h0101_0101;
        if (s == 2) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        int s = op_size(op);
        int o = eff_off(op, addr);
        longint unsigned raw;
        raw = (64'(word) >> (8 * (4 - o - s))) & ((64'd1 << (8 * s)) - 64'd1);
        if ((op == OP_LB || op == OP_LH) && raw >= (64'd1 << (8 * s - 1)))
            raw = raw + 64'h1_0000_0000 - (64'd1 << (8 * s));
        return raw[31:0];
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return init_word(wa);
    endfunction

    // Model store: the byte at offset k (o <= k < o+s) takes the matching big-endian byte of sd.
    function automatic void ref_store(input logic [3:0] op, input logic [31:0] addr,
                                      input logic [31:0] sd);
        int s = op_size(op);
        int o = eff_off(op, addr);
        logic [31:0] wa = {addr[31:2], 2'b00};
        logic [31:0] w = ref_rd(wa);
        for (int k = o; k < o + s; k++) begin
            w[31 - 8 * k -: 8] = 8'((sd >> (8 * (s - 1 - (k - o)))) & 32'hFF);
        end
        ref_mem[wa] = w;
    endfunction

    // Bus slave memory updated from whatever the DUT puts on the bus.
    function automatic void bus_write(input logic [31:0] wa, input logic [3:0] sel,
                                      input logic [31:0] data);
        logic [31:0] w = bus_rd(wa);
        for (int i = 0; i < 4; i++)
            if (sel[i]) w[8 * i +: 8] = data[8 * i +: 8];
        bus_mem[wa] = w;
    endfunction

    function automatic void set_word(input logic [31:0] wa, input logic [31:0] v);
        ref_mem[wa] = v;
        bus_mem[wa] = v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input int delay, input int hold, output logic [31:0] got);
        logic [31:0] wa, alu, exp_res, req_addr, req_wdata;
        logic [3:0]  req_sel;
        logic        req_we, wreg;
        logic [4:0]  wd;
        bit          ld, st, err, acc, seen_req, stable;
        int          stall_cyc, wait_cnt, cyc;
        wd   = 5'($urandom_range(0, 31));
        wreg = 1'($urandom_range(0, 1));
        alu  = $urandom;
        ld   = op_is_load(op);
        st   = op_is_store(op);
        err  = ALIGN_EXC && (ld || st) && op_misaligned(op, addr);
        acc  = (ld || st) && !err;
        wa   = {addr[31:2], 2'b00};
        got  = 32'd0;

        @(posedge clk); #1;
        ex_memop = op; ex_memaddr = addr; ex_storedata = sd;
        ex_wd = wd; ex_wreg = wreg; ex_wdata = alu;
        stall = '0; flush = 1'b0; bus_ack = 1'b0;

        if (!acc) begin
            @(negedge clk);
            check("noacc_stallreq", 32'(stallreq), 32'd0);
            check("noacc_adel", 32'(mem_adel), 32'(err && ld));
            check("noacc_ades", 32'(mem_ades), 32'(err && st));
            check("noacc_wreg", 32'(mem_wreg), 32'(wreg && !err));
            check("noacc_wd", 32'(mem_wd), 32'(wd));
            check("noacc_wdata", mem_wdata, ld ? last_cap : alu);
            got = mem_wdata;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("noacc_no_req", 32'(bus_req), 32'd0);
            end
        end else begin
            if (ld) exp_q.push_back(exp_load(op, addr, ref_rd(wa)));
            else begin
                ref_store(op, addr, sd);
                exp_q.push_back(alu);
            end
            stall_cyc = 0; wait_cnt = 0; cyc = 0; seen_req = 0; stable = 1;
            req_we = 0; req_addr = 0; req_sel = 0; req_wdata = 0;
            forever begin
                @(negedge clk);
                if (!stallreq) break;
                stall_cyc++;
                if (bus_req) begin
                    if (!seen_req) begin
                        seen_req  = 1;
                        req_we    = bus_we;
                        req_addr  = bus_addr;
                        req_sel   = bus_sel;
                        req_wdata = bus_wdata;
                        check("req_we", 32'(bus_we), 32'(st));
                        check("req_addr", bus_addr, wa);
                        check("req_sel", 32'(bus_sel), 32'(exp_sel(op, addr)));
                        if (st) check("req_wdata", bus_wdata, exp_wdata(op, sd));
                    end else if ({bus_we, bus_addr, bus_sel, bus_wdata} !==
                                 {req_we, req_addr, req_sel, req_wdata}) begin
                        stable = 0;
                    end
                    if (wait_cnt == delay) begin
                        bus_ack = 1'b1;
                        if (ld) bus_rdata = bus_rd(bus_addr);
                        else begin
                            bus_rdata = $urandom;
                            bus_write(bus_addr, bus_sel, bus_wdata);
                        end
                    end else begin
                        bus_ack = 1'b0;
                    end
                    wait_cnt++;
                end else begin
                    bus_ack = 1'b0;
                end
                cyc++;
                if (cyc > 40) begin
                    check("timeout_wait_done", 32'd1, 32'd0);
                    break;
                end
            end
            bus_ack = 1'b0;
            exp_res = exp_q.pop_front();
            check("stall_cycles", 32'(stall_cyc), 32'(delay + 2));
            check("req_seen", 32'(seen_req), 32'd1);
            check("bus_stable", 32'(stable), 32'd1);
            check("done_bus_req", 32'(bus_req), 32'd0);
            check("mem_wdata", mem_wdata, exp_res);
            check("mem_wreg", 32'(mem_wreg), 32'(wreg));
            check("mem_wd", 32'(mem_wd), 32'(wd));
            got = mem_wdata;
            if (ld) last_cap = exp_res;
            if (hold > 0) begin
                stall = 6'b010000;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    check("hold_stallreq", 32'(stallreq), 32'd0);
                    check("hold_bus_req", 32'(bus_req), 32'd0);
                    check("hold_wdata", mem_wdata, exp_res);
                end
                stall = '0;
            end
        end
        @(posedge clk); #1;
        ex_memop = 4'd0;
    endtask

    // Flush during WAIT; the ack arrives either with the flush or one cycle later.
    task automatic flush_in_wait(input bit same_cycle);
        @(posedge clk); #1;
        ex_memop = OP_LW; ex_memaddr = 32'h140; ex_wreg = 1'b1; ex_wdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        check("flush_pre_req", 32'(bus_req), 32'd1);
        flush = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        bus_ack = same_cycle;
        @(negedge clk);
        check("flush_bus_req", 32'(bus_req), 32'd0);
        check("flush_state", 32'(dbg_state), 32'(IDLE_ENC));
        bus_ack = !same_cycle;
        if (!same_cycle) begin
            flush = 1'b0;
            ex_memop = 4'd0;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        check("flush_ack_ignored_req", 32'(bus_req), 32'd0);
        check("flush_ack_ignored_state", 32'(dbg_state), 32'(IDLE_ENC));
        ex_memop = OP_LW;
        flush = 1'b1;
        #1;
        check("flush_data_discarded", mem_wdata, last_cap);
        @(posedge clk); #1;
        flush = 1'b0;
        ex_memop = 4'd0;
    endtask

    task automatic reset_in_wait();
        @(posedge clk); #1;
        ex_memop = OP_SW; ex_memaddr = 32'h180; ex_storedata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        check("rstw_pre_req", 32'(bus_req), 32'd1);
        check("rstw_pre_we", 32'(bus_we), 32'd1);
        rst = 1'b0;
        #1;
        check("rstw_bus_req", 32'(bus_req), 32'd0);
        check("rstw_bus_we", 32'(bus_we), 32'd0);
        check("rstw_bus_addr", bus_addr, 32'd0);
        check("rstw_bus_sel", 32'(bus_sel), 32'd0);
        check("rstw_bus_wdata", bus_wdata, 32'd0);
        check("rstw_state", 32'(dbg_state), 32'(IDLE_ENC));
        check("rstw_stallreq", 32'(stallreq), 32'd0);
        ex_memop = OP_LW; ex_memaddr = 32'h181;
        #1;
        check("rstw_adel", 32'(mem_adel), 32'd0);
        check("rstw_stallreq_ld", 32'(stallreq), 32'd0);
        check("rstw_captured", mem_wdata, 32'd0);
        @(negedge clk);
        ex_memop = 4'd0;
        rst = 1'b1;
        @(negedge clk);
        check("rstw_after_req", 32'(bus_req), 32'd0);
        check("rstw_no_store", bus_rd(32'h180), ref_rd(32'h180));
    endtask

    // ---------------- main sequence and final report ----------------
    initial begin
        logic [31:0] got;
        logic [3:0]  op;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE_ENC));
        rst = 1'b1;

        set_word(32'h100, 32'h1234_5678);
        run_op(OP_LW, 32'h100, 32'd0, 2, 0, got);
        check("lw_0x100", got, 32'h1234_5678);
        set_word(32'h100, 32'h0000_00F0);
        run_op(OP_LB, 32'h103, 32'd0, 0, 1, got);
        check("lb_0x103", got, 32'hFFFF_FFF0);
        run_op(OP_LBU, 32'h103, 32'd0, 1, 0, got);
        check("lbu_0x103", got, 32'h0000_00F0);
        run_op(OP_SH, 32'h202, 32'h0000_ABCD, 0, 2, got);
        run_op(OP_LW, 32'h200, 32'd0, 0, 0, got);
        run_op(OP_LW, 32'h101, 32'd0, 1, 0, got);
        run_op(OP_LH, 32'h203, 32'd0, 0, 0, got);
        run_op(OP_SW, 32'h10E, 32'h8765_4321, 3, 0, got);

        for (int i = 0; i < 160; i++) begin
            op = 4'($urandom_range(0, 15));
            run_op(op, 32'h100 + 32'($urandom_range(0, 31)), $urandom,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), got);
        end

        flush_in_wait(1'b0);
        flush_in_wait(1'b1);
        reset_in_wait();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (rst==0 resets immediately, independent of clk).
REQ-003 ex_wd  in  5  destination GPR index from EX/MEM.
REQ-004 ex_wreg  in  1  GPR write enable from EX/MEM.
REQ-005 ex_wdata  in  32  ALU result, used for non-memory ops.
REQ-006 ex_memop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-007 ex_memaddr  in  32  effective byte address.
REQ-008 ex_storedata  in  32  store source register value.
REQ-009 stall  in  6  pipeline stall vector; bit 4 = MEM stage held (1 = STOP).
REQ-010 flush  in  1  exception flush; kills the in-flight access.
REQ-011 bus_req  out  1  registered data-bus request.
REQ-012 bus_we  out  1  registered write strobe (1 = store).
REQ-013 bus_addr  out  32  registered word address, bits [1:0] = 0.
REQ-014 bus_sel  out  4  registered byte enables, big-endian (sel[3] = byte at addr offset 0).
REQ-015 bus_wdata  out  32  registered store data, replicated into the selected lanes.
REQ-016 bus_rdata  in  32  read data, valid in the ack cycle.
REQ-017 bus_ack  in  1  one-cycle completion strobe from the bus.
REQ-018 mem_wd / mem_wreg / mem_wdata  out  5/1/32  result to MEM_WB.
REQ-019 mem_adel / mem_ades  out  1/1  load / store address-error flags.
REQ-020 stallreq  out  1  combinational request to hold the pipeline.

Function
REQ-021 FSM states are IDLE, WAIT, DONE.
REQ-022 IDLE: on a valid memop with an aligned (or forced-aligned) address and flush==0, the block SHALL register bus_req=1 and the bus_we/addr/sel/wdata values, then move to WAIT on the next edge.
REQ-023 WAIT: bus outputs SHALL hold stable until bus_ack; on bus_ack the block SHALL capture extended read data, drop bus_req and move to DONE. Latency is 1 + N cycles for an ack arriving N cycles after the request.
REQ-024 DONE: the block SHALL move to IDLE when stall[4]==0; it SHALL remain in DONE while stall[4]==1.
REQ-025 stallreq SHALL be 1 when memop is valid and state is IDLE or WAIT; it SHALL be 0 in DONE, for op none and for address-error ops.
REQ-026 Load extension: LB/LH sign-extend; LBU/LHU zero-extend. Lane selection is big-endian by addr[1:0]; LW returns bus_rdata unchanged.
REQ-027 Store lanes: SB sel = 1000/0100/0010/0001 for offsets 0-3; SH sel = 1100/0011 for offsets 0/2; SW sel = 1111.
REQ-028 mem_wdata SHALL be the captured load data for loads and ex_wdata otherwise. mem_wd and mem_wreg SHALL pass through ex_wd and ex_wreg.
REQ-029 flush==1 in any state SHALL force IDLE and bus_req=0 on the next edge. A bus_ack received in IDLE or DONE SHALL be ignored.
REQ-030 A flush and a bus_ack in the same cycle: flush wins and the data is discarded.

Reset
REQ-031 rst==0 SHALL force: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_sel 0, bus_wdata 0, captured data 0.
REQ-032 During reset, stallreq, mem_adel and mem_ades SHALL read 0.
REQ-033 Reset during WAIT SHALL abort the access; no write-back of that access occurs.

Configuration
REQ-034 Macro MEM_ALIGN_EXC_EN, when defined: a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) access SHALL raise mem_adel (load) or mem_ades (store), force mem_wreg=0, and issue no bus request.
REQ-035 Macro MEM_ALIGN_EXC_EN, when undefined: mem_adel and mem_ades SHALL be tied to 0, and misaligned addresses SHALL be truncated to natural alignment before the access proceeds.

Verification
REQ-036 LW at 0x100, ack 3 cycles later with rdata 0x12345678 -> stallreq high for 4 cycles; mem_wdata=0x12345678; bus_sel=1111.
REQ-037 LB at 0x103, rdata 0x000000F0 -> mem_wdata=0xFFFFFFF0. LBU at the same address -> 0x000000F0.
REQ-038 SH at 0x202, storedata 0x0000ABCD -> bus_we=1, bus_addr=0x200, bus_sel=0011, bus_wdata=0xABCDABCD.
REQ-039 LW at 0x101 with macro defined -> mem_adel=1, mem_wreg=0, bus_req never asserted, stallreq=0. Without the macro -> bus_addr=0x100.
REQ-040 flush asserted while in WAIT, ack arrives 1 cycle later -> state IDLE, bus_req=0, ack ignored. rst pulsed low in WAIT -> all registered outputs 0 immediately.
